// File: rtl/bus_master_pkg.sv
// rtl/bus_master_pkg.sv - shared types and constants for the burst bus master
package bus_master_pkg;

  localparam int LEN_W     = 4;
  localparam int MAX_BEATS = 16;
  localparam int CNT_W     = $clog2(MAX_BEATS) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    XFER  = 2'd2,
    RLAST = 2'd3
  } state_t;

  // Length field encodes 1..15 directly; zero stands for a full 16-beat burst.
  function automatic logic [CNT_W-1:0] len_to_beats(input logic [LEN_W-1:0] len);
    return (len == '0) ? CNT_W'(MAX_BEATS) : CNT_W'(len);
  endfunction

endpackage

// File: rtl/bus_master_ctrl.sv
// rtl/bus_master_ctrl.sv - burst read/write bus master with grant handshake
module bus_master_ctrl
  import bus_master_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wd_valid,
  output logic              wd_ready,
  input  logic [DATA_W-1:0] wd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              m_req,
  output logic              m_wr,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_dout,
  input  logic              m_grant,
  input  logic [DATA_W-1:0] m_din,
  output logic              busy,
  output logic              done
);

  state_t             state;
  state_t             state_nxt;
  logic               wr_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               rsp_q;
  logic               done_q;
  logic               beat;
  logic               last_beat;

  // A beat needs the grant, and for writes also a word on the write stream.
  assign beat      = (state == XFER) && m_grant && (!wr_q || wd_valid);
  assign last_beat = beat && (cnt_q == CNT_W'(1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode: writes finish straight to IDLE, reads drain through RLAST.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid) state_nxt = REQ;
      REQ:     if (m_grant) state_nxt = XFER;
      XFER:    if (last_beat) state_nxt = wr_q ? IDLE : RLAST;
      RLAST:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Command latch, address/beat counters and the one-cycle-late read/done flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q   <= 1'b0;
      addr_q <= '0;
      cnt_q  <= '0;
      rsp_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rsp_q  <= beat && !wr_q;
      done_q <= last_beat && wr_q;
      if (state == IDLE && cmd_valid) begin
        wr_q   <= cmd_wr;
        addr_q <= cmd_addr;
        cnt_q  <= len_to_beats(cmd_len);
      end else if (beat) begin
        addr_q <= addr_q + ADDR_W'(1);
        cnt_q  <= cnt_q - CNT_W'(1);
      end
    end
  end

  // Output decode; bus outputs are forced to zero whenever no transfer is owed.
  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b0;
    m_req     = 1'b0;
    m_wr      = 1'b0;
    m_addr    = '0;
    m_dout    = '0;
    wd_ready  = 1'b0;
    rsp_valid = rsp_q;
    rsp_data  = rsp_q ? m_din : '0;
    done      = done_q || (state == RLAST);
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
      end
      REQ: begin
        busy   = 1'b1;
        m_req  = 1'b1;
        m_addr = addr_q;
      end
      XFER: begin
        busy     = 1'b1;
        m_req    = 1'b1;
        m_addr   = addr_q;
        m_wr     = beat && wr_q;
        wd_ready = beat && wr_q;
        m_dout   = (beat && wr_q) ? wd_data : '0;
      end
      RLAST: begin
        busy = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_bus_master_ctrl.sv
// tb/tb_bus_master_ctrl.sv - scoreboard bench for bus_master_ctrl
module tb_bus_master_ctrl;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_wr;
  logic [ADDR_W-1:0] cmd_addr;
  logic [3:0]        cmd_len;
  logic              wd_valid;
  logic              wd_ready;
  logic [DATA_W-1:0] wd_data;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              m_req;
  logic              m_wr;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_dout;
  logic              m_grant;
  logic [DATA_W-1:0] m_din;
  logic              busy;
  logic              done;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [47:0] exp_wr[$];
  logic [31:0] exp_rsp[$];
  bit          exp_done[$];
  logic [31:0] nxt_din = '0;

  bus_master_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_dout(m_dout),
    .m_grant(m_grant), .m_din(m_din),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] a_off(input logic [15:0] a, input int i);
    return a + 16'(i);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Slave RAM holding mem[i] = i: address seen in one cycle is returned the next.
  initial begin
    m_din = '0;
    forever begin
      @(posedge clk);
      m_din = nxt_din;
    end
  end
  initial begin
    forever begin
      @(negedge clk);
      nxt_din = {16'h0000, m_addr};
    end
  end

  // Monitor: pops expectations whenever the DUT presents a beat, response or done.
  initial begin
    bit          prev_wr = 1'b0;
    bit          k;
    logic [47:0] w;
    logic [31:0] r;
    forever begin
      @(negedge clk);
      check("ready_vs_busy", cmd_ready, !busy);
      check("wdready_vs_mwr", wd_ready, m_wr);
      if (rsp_valid) begin
        if (exp_rsp.size() == 0) check("rsp_extra", rsp_valid, 0);
        else begin
          r = exp_rsp.pop_front();
          check("rsp_data", rsp_data, r);
        end
      end
      if (m_wr) begin
        if (exp_wr.size() == 0) check("wr_extra", m_wr, 0);
        else begin
          w = exp_wr.pop_front();
          check("wr_addr", 32'(m_addr), 32'(w[47:32]));
          check("wr_data", m_dout, w[31:0]);
        end
      end
      if (done) begin
        if (exp_done.size() == 0) check("done_extra", done, 0);
        else begin
          k = exp_done.pop_front();
          if (k) begin
            check("done_with_rsp", rsp_valid, 1);
            check("done_rsp_left", 32'(exp_rsp.size()), 0);
          end else begin
            check("done_after_wr", prev_wr, 1);
            check("done_wr_left", 32'(exp_wr.size()), 0);
          end
        end
      end
      prev_wr = m_wr;
    end
  end

  task automatic issue(input bit wr, input logic [15:0] a, input logic [3:0] len);
    int t = 0;
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_len = len;
    @(negedge clk);
    while (!cmd_ready && t < 100) begin
      tick();
      @(negedge clk);
      t++;
    end
    check("cmd_accept", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("burst_end", busy, 0);
    tick();
    tick();
  endtask

  task automatic do_write(input logic [15:0] a, input int n, input int gdelay,
                          input int stall_beat, input int stall_cyc);
    int beats = (n == 0) ? 16 : n;
    int i = 0, st = 0, t = 0;
    for (int j = 0; j < beats; j++) exp_wr.push_back({a_off(a, j), a_off(a, j), 16'(j)});
    exp_done.push_back(1'b0);
    m_grant = 1'b0; wd_valid = 1'b0;
    issue(1'b1, a, 4'(n));
    repeat (gdelay) tick();
    m_grant = 1'b1;
    while (i < beats && t < 300) begin
      if (i == stall_beat && st < stall_cyc) begin
        wd_valid = 1'b0;
        @(negedge clk);
        check("stall_no_wr", m_wr, 0);
        check("stall_addr_held", 32'(m_addr), 32'(a_off(a, i)));
        st++;
      end else begin
        wd_valid = 1'b1;
        wd_data  = {a_off(a, i), 16'(i)};
        @(negedge clk);
        if (wd_ready) i++;
      end
      tick();
      t++;
    end
    check("wr_beats", i, beats);
    wd_valid = 1'b0; wd_data = '0; m_grant = 1'b0;
    wait_idle();
  endtask

  task automatic do_read(input logic [15:0] a, input int n, input int gdelay,
                         input int gap_at, input int gap_cyc);
    int beats = (n == 0) ? 16 : n;
    int b = 0, g = 0, t = 0;
    for (int j = 0; j < beats; j++) exp_rsp.push_back({16'h0000, a_off(a, j)});
    exp_done.push_back(1'b1);
    m_grant = 1'b0;
    issue(1'b0, a, 4'(n));
    repeat (gdelay) tick();
    m_grant = 1'b1;
    tick();
    while (b < beats && t < 300) begin
      if (b == gap_at && g < gap_cyc) begin
        m_grant = 1'b0;
        @(negedge clk);
        check("gap_addr_held", 32'(m_addr), 32'(a_off(a, b)));
        check("gap_req_held", m_req, 1);
        if (g > 0) check("gap_no_rsp", rsp_valid, 0);
        g++;
      end else begin
        m_grant = 1'b1;
        b++;
      end
      tick();
      t++;
    end
    m_grant = 1'b0;
    wait_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
    wd_valid = 1'b0; wd_data = '0; m_grant = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_m_req", m_req, 0);
    check("rst_m_addr", 32'(m_addr), 0);
    check("rst_done", done, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    tick();
    reset = 1'b0;
    tick();

    do_write(16'h0010, 4, 2, -1, 0);
    do_read(16'h0020, 0, 0, -1, 0);
    do_write(16'h0100, 3, 0, 1, 3);
    do_read(16'hFFFE, 3, 1, -1, 0);
    do_read(16'h0040, 6, 0, 2, 2);

    // Reset during the second beat of an 8-beat write: two beats seen, no done.
    exp_wr.push_back({16'h0200, 32'h0200_0000});
    exp_wr.push_back({16'h0201, 32'h0201_0001});
    m_grant = 1'b1;
    issue(1'b1, 16'h0200, 4'd8);
    wd_valid = 1'b1; wd_data = 32'h0200_0000;
    tick();
    tick();
    wd_data = 32'h0201_0001;
    reset = 1'b1;
    tick();
    reset = 1'b0; wd_valid = 1'b0; wd_data = '0; m_grant = 1'b0;
    @(negedge clk);
    check("midrst_m_req", m_req, 0);
    check("midrst_busy", busy, 0);
    check("midrst_cmd_ready", cmd_ready, 1);
    check("midrst_done", done, 0);
    check("midrst_m_wr", m_wr, 0);
    check("midrst_m_addr", 32'(m_addr), 0);
    repeat (5) tick();

    check("wr_queue_empty", 32'(exp_wr.size()), 0);
    check("rsp_queue_empty", 32'(exp_rsp.size()), 0);
    check("done_queue_empty", 32'(exp_done.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
